// File: rtl/operand_skew_feeder.sv
// Operand skew feeder: staggers each accepted operand row across N lanes so that
// lane i is delayed by i+1 array-advance cycles, feeding one edge of a systolic array.
module operand_skew_feeder #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_row,
  input  logic            in_last,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_lane_valid,
  output logic            busy,
  output logic            tile_done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    FEED  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            accept_c;
  logic [N-1:0]    lane_busy;

  // Next-state, drain counter and ready/accept decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    in_ready = (state_q == FEED) && adv;
    accept_c = in_valid && in_ready;
    if (adv) begin
      case (state_q)
        FEED: begin
          if (accept_c && in_last) begin
            state_d = DRAIN;
            cnt_d   = CW'(N - 1);
          end
        end
        DRAIN: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = FEED;
            done_d  = 1'b1;
          end
        end
        default: state_d = FEED;
      endcase
    end
  end

  // State, counter and the single-cycle tile_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Lane i is a chain of i+1 data/valid stages; the last stage drives the array edge.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] dat_q [i+1];
    logic [i:0]    vld_q;

    // Shift the lane on every advance; stage 0 takes the accepted element or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) dat_q[s] <= '0;
        vld_q <= '0;
      end else if (adv) begin
        dat_q[0] <= accept_c ? in_row[i*DW +: DW] : '0;
        vld_q[0] <= accept_c;
        for (int s = 1; s <= i; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    assign out_data[i*DW +: DW] = dat_q[i];
    assign out_lane_valid[i]    = vld_q[i];
    assign lane_busy[i]         = |vld_q;
  end

  assign busy      = (state_q == DRAIN) || (|lane_busy);
  assign tile_done = done_q;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder with N=4, DW=8.
module tb_operand_skew_feeder;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            adv;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_row;
  logic            in_last;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_lane_valid;
  logic            busy;
  logic            tile_done;

  int checks = 0;
  int errors = 0;

  operand_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .adv            (adv),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_row         (in_row),
    .in_last        (in_last),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .busy           (busy),
    .tile_done      (tile_done)
  );

  always #5 clk = ~clk;

  // Single row 0x44332211 with in_last: expected state after each of 5 edges.
  localparam logic [31:0] SGL_D [5] = '{32'h00000011, 32'h00002200, 32'h00330000, 32'h44000000, 32'h0};
  localparam logic [3:0]  SGL_V [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  localparam logic        SGL_T [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic        SGL_R [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic        SGL_B [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // Four back-to-back rows, byte = 0x10*(k+1)+lane.
  localparam logic [31:0] B2B_ROW [4] = '{32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140};
  localparam logic [31:0] B2B_D [7] = '{32'h00000010, 32'h00001120, 32'h00122130, 32'h13223140,
                                        32'h23324100, 32'h33420000, 32'h43000000};
  localparam logic [3:0]  B2B_V [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
  localparam logic        B2B_T [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // adv toggling after accepting 0x44332211.
  localparam logic        TGL_A [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] TGL_D [7] = '{32'h00002200, 32'h00002200, 32'h00330000, 32'h00330000,
                                        32'h44000000, 32'h44000000, 32'h0};
  localparam logic [3:0]  TGL_V [7] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
  localparam logic        TGL_T [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic        TGL_R [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Two-row tile then a one-row tile offered in the tile_done cycle.
  localparam logic        NXT_IV [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic        NXT_IL [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [31:0] NXT_ROW [10] = '{32'h13121110, 32'h23222120, 32'h0, 32'h0, 32'h0,
                                           32'h88776655, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] NXT_D [10] = '{32'h00000010, 32'h00001120, 32'h00122100, 32'h13220000,
                                         32'h23000000, 32'h00000055, 32'h00006600, 32'h00770000,
                                         32'h88000000, 32'h0};
  localparam logic [3:0]  NXT_V [10] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000,
                                         4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  localparam logic        NXT_T [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_row   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adv   = 1'b1;
    idle_inputs();
    #3;
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp %h", out_data, 32'h0); end
    checks++; if (out_lane_valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0000", out_lane_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", tile_done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_adv1: got %b exp 1", in_ready); end
    adv = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_adv0: got %b exp 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    adv   = 1'b1;
    step();
  endtask

  task automatic test_single(input string tag);
    adv      = 1'b1;
    in_valid = 1'b1;
    in_row   = 32'h44332211;
    in_last  = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_accept: got %b exp 1", tag, in_ready); end
    for (int k = 0; k < 5; k++) begin
      step();
      idle_inputs();
      #1;
      checks++; if (out_data !== SGL_D[k]) begin errors++; $display("FAIL %s_data[%0d]: got %h exp %h", tag, k, out_data, SGL_D[k]); end
      checks++; if (out_lane_valid !== SGL_V[k]) begin errors++; $display("FAIL %s_valid[%0d]: got %b exp %b", tag, k, out_lane_valid, SGL_V[k]); end
      checks++; if (tile_done !== SGL_T[k]) begin errors++; $display("FAIL %s_done[%0d]: got %b exp %b", tag, k, tile_done, SGL_T[k]); end
      checks++; if (in_ready !== SGL_R[k]) begin errors++; $display("FAIL %s_ready[%0d]: got %b exp %b", tag, k, in_ready, SGL_R[k]); end
      checks++; if (busy !== SGL_B[k]) begin errors++; $display("FAIL %s_busy[%0d]: got %b exp %b", tag, k, busy, SGL_B[k]); end
    end
  endtask

  task automatic test_back_to_back();
    adv = 1'b1;
    for (int t = 0; t < 7; t++) begin
      if (t < 4) begin
        in_valid = 1'b1;
        in_row   = B2B_ROW[t];
        in_last  = (t == 3);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp 1", t, in_ready); end
      end else begin
        idle_inputs();
      end
      step();
      checks++; if (out_data !== B2B_D[t]) begin errors++; $display("FAIL b2b_data[%0d]: got %h exp %h", t, out_data, B2B_D[t]); end
      checks++; if (out_lane_valid !== B2B_V[t]) begin errors++; $display("FAIL b2b_valid[%0d]: got %b exp %b", t, out_lane_valid, B2B_V[t]); end
      checks++; if (tile_done !== B2B_T[t]) begin errors++; $display("FAIL b2b_done[%0d]: got %b exp %b", t, tile_done, B2B_T[t]); end
    end
    idle_inputs();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b exp 0", busy); end
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL b2b_done_end: got %b exp 0", tile_done); end
  endtask

  task automatic test_adv_toggle();
    adv      = 1'b1;
    in_valid = 1'b1;
    in_row   = 32'h44332211;
    in_last  = 1'b1;
    step();
    idle_inputs();
    checks++; if (out_data !== 32'h00000011) begin errors++; $display("FAIL tgl_accept: got %h exp %h", out_data, 32'h00000011); end
    for (int j = 0; j < 7; j++) begin
      adv = TGL_A[j];
      #1;
      checks++; if (in_ready !== TGL_R[j]) begin errors++; $display("FAIL tgl_ready[%0d]: got %b exp %b", j, in_ready, TGL_R[j]); end
      step();
      checks++; if (out_data !== TGL_D[j]) begin errors++; $display("FAIL tgl_data[%0d]: got %h exp %h", j, out_data, TGL_D[j]); end
      checks++; if (out_lane_valid !== TGL_V[j]) begin errors++; $display("FAIL tgl_valid[%0d]: got %b exp %b", j, out_lane_valid, TGL_V[j]); end
      checks++; if (tile_done !== TGL_T[j]) begin errors++; $display("FAIL tgl_done[%0d]: got %b exp %b", j, tile_done, TGL_T[j]); end
    end
    adv = 1'b1;
  endtask

  task automatic test_stall_input();
    adv      = 1'b0;
    in_valid = 1'b1;
    in_row   = 32'hDEADBEEF;
    in_last  = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b exp 0", in_ready); end
    step();
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL stall_data: got %h exp 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy: got %b exp 0", busy); end
    in_valid = 1'b0;
    adv      = 1'b1;
    step();
    checks++; if (out_lane_valid !== 4'b0) begin errors++; $display("FAIL stall_after_valid: got %b exp 0000", out_lane_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL last_ignored_ready: got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL last_ignored_busy: got %b exp 0", busy); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    adv      = 1'b1;
    in_valid = 1'b1;
    in_row   = 32'h44332211;
    in_last  = 1'b1;
    step();
    idle_inputs();
    step();
    checks++; if (out_data !== 32'h00002200) begin errors++; $display("FAIL arst_pre: got %h exp %h", out_data, 32'h00002200); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_lane_valid !== 4'b0) begin errors++; $display("FAIL arst_valid: got %b exp 0000", out_lane_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b exp 0", busy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL arst_data: got %h exp 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b exp 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL arst_done[%0d]: got %b exp 0", k, tile_done); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL arst_post_done[%0d]: got %b exp 0", k, tile_done); end
    end
    test_single("post_rst");
  endtask

  task automatic test_next_tile();
    adv = 1'b1;
    for (int t = 0; t < 10; t++) begin
      in_valid = NXT_IV[t];
      in_last  = NXT_IL[t];
      in_row   = NXT_ROW[t];
      #1;
      if (t == 5) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL next_ready: got %b exp 1", in_ready); end
      end
      step();
      checks++; if (out_data !== NXT_D[t]) begin errors++; $display("FAIL next_data[%0d]: got %h exp %h", t, out_data, NXT_D[t]); end
      checks++; if (out_lane_valid !== NXT_V[t]) begin errors++; $display("FAIL next_valid[%0d]: got %b exp %b", t, out_lane_valid, NXT_V[t]); end
      checks++; if (tile_done !== NXT_T[t]) begin errors++; $display("FAIL next_done[%0d]: got %b exp %b", t, tile_done, NXT_T[t]); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_back_to_back();
    test_adv_toggle();
    test_stall_input();
    test_async_reset();
    test_next_tile();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

Interface
REQ-001 Parameter N, default 8: systolic array edge length, i.e. the number of lanes; legal range 2..32.
REQ-002 Parameter DW, default 8: width of each lane element, in bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 adv  input  1  array advance enable; when 0, all state holds.
REQ-006 in_valid  input  1  an operand row is offered by the DMA.
REQ-007 in_ready  output  1  the block accepts the offered row this cycle.
REQ-008 in_row  input  N*DW  operand row; lane i occupies bits [i*DW +: DW].
REQ-009 in_last  input  1  the offered row is the final row of the tile.
REQ-010 out_data  output  N*DW  skewed edge data to the array; lane i occupies bits [i*DW +: DW].
REQ-011 out_lane_valid  output  N  bit i is set when lane i of out_data carries live data.
REQ-012 busy  output  1  the block holds live data or is draining.
REQ-013 tile_done  output  1  single-cycle pulse marking the end of the tile drain.

Function
REQ-014 The block SHALL have two states: FEED and DRAIN.
REQ-015 in_ready SHALL equal (state==FEED) && adv; it is combinational, and in_ready SHALL NOT depend on in_valid.
REQ-016 A row is accepted when in_valid && in_ready are both 1.
REQ-017 Lane i SHALL be a shift chain of i+1 registers (data plus valid bit); its final stage drives out_data lane i and out_lane_valid[i].
REQ-018 On each adv=1 edge, stage 0 of lane i SHALL load in_row lane i with valid=1 if a row is accepted; otherwise it loads 0 with valid=0 (bubble).
REQ-019 On each adv=1 edge, every other stage SHALL load from its predecessor.
REQ-020 On adv=0 edges, all stages, the state, and the drain counter SHALL hold.
REQ-021 Latency: an element accepted on lane i SHALL appear on out_data lane i after exactly i+1 adv=1 edges, counting the accepting edge.
REQ-022 Back-to-back acceptance SHALL be sustained at one row per adv cycle.
REQ-023 Transition FEED->DRAIN SHALL occur on an accepting edge with in_last=1; the drain counter loads N-1 on that edge.
REQ-024 In DRAIN, each adv=1 edge SHALL inject a bubble and decrement the counter.
REQ-025 The edge on which the counter goes from 1 to 0 SHALL return the state to FEED and set tile_done=1 for exactly one clk cycle.
REQ-026 In the cycle tile_done is 1, out_lane_valid[N-1] SHALL be 1 and SHALL carry the last row's lane N-1 element.
REQ-027 busy SHALL equal (state==DRAIN) OR (any stage valid bit set).
REQ-028 in_last with in_valid=0, or on a non-accepting cycle, SHALL be ignored.
REQ-029 A new tile MAY be accepted in the cycle after tile_done, while lanes are still flushing earlier data. No gap is required; earlier data keeps shifting out unaffected.
REQ-030 Data SHALL pass through unmodified: no arithmetic and no width change.

Reset
REQ-031 When rst_n=0, the block SHALL immediately, without waiting for clk, force:
- all stages and valid bits to 0
- state to FEED
- drain counter to 0
- tile_done to 0
REQ-032 Resulting output values during reset: out_data=0, out_lane_valid=0, busy=0, in_ready=adv.
REQ-033 Reset asserted mid-tile or mid-drain SHALL discard all in-flight data; no tile_done is produced for the aborted tile.
REQ-034 After rst_n deasserts, the first edge with adv=1 and in_valid=1 SHALL accept a row normally.

Verification
REQ-035 N=4, DW=8, adv=1 held; one row 0x44332211 sent with in_last=1. Required response:
- out_data lane0=0x11 one cycle after acceptance
- lane1=0x22 after 2 cycles, lane2=0x33 after 3, lane3=0x44 after 4
- tile_done pulses in the 4th cycle
- in_ready=0 for cycles 1..3 after acceptance
REQ-036 N=4; four back-to-back rows R0..R3, in_last on R3. Required response:
- each lane shows R0..R3 consecutively with its skew offset
- out_lane_valid walks 0001, 0011, 0111, 1111, 1110, 1100, 1000
- tile_done pulses with lane3=R3
REQ-037 Toggle adv 1,0,1,0 during DRAIN. Required response:
- outputs and counter freeze on adv=0 cycles
- tile_done arrives after exactly 3 adv=1 edges following acceptance of the last row
REQ-038 in_valid=1 with adv=0. Required response: in_ready=0, no acceptance, all outputs unchanged.
REQ-039 Assert rst_n=0 asynchronously, mid-clock, during DRAIN. Required response:
- out_lane_valid=0 and busy=0 before the next clk edge
- no tile_done pulse
- a new tile after reset behaves as in REQ-035
REQ-040 Start a second tile in the cycle after tile_done. Required response:
- the first row of the second tile is accepted on the following cycle
- the tail of the first tile continues uncorrupted on the upper lanes
